// File: rtl/ysyx_24070016_mem_arbiter_if.sv
// Bundle of the three request/response channels around the memory arbiter:
// fetch (IFU), data (LSU) and the shared memory port.
// The slave view belongs to the arbiter; the master view belongs to its
// surroundings (requesters plus the memory/bus bridge).
interface ysyx_24070016_mem_arbiter_if;
  // instruction fetch channel
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  // load/store channel
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  // shared memory port
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_rsp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_rsp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready
  );
endinterface

// File: rtl/ysyx_24070016_mem_arbiter.sv
// Shares the single memory port between the fetch unit and the load/store
// unit. One transaction is in flight at a time; ties go round-robin, request
// fields are latched for the whole transaction, and error responses are
// generated locally for misaligned fetches and memory timeouts.
module ysyx_24070016_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  ysyx_24070016_mem_arbiter_if.slave bus
);

  // A zero TIMEOUT still needs a one-bit counter so the declaration is legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The timeout fires on the cycle whose increment would make the counter
  // reach TIMEOUT, so the owner waits exactly TIMEOUT cycles in RSP.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            owner;        // 0 = IFU, 1 = LSU
  logic            last;         // owner of the most recent grant
  logic [31:0]     addr;
  logic            wen;
  logic [31:0]     wdata;
  logic [3:0]      wmask;
  logic [CW-1:0]   cnt;

  logic            grant_lsu;
  logic            grant_ifu;
  logic            accept;
  logic            misaligned;
  logic            owner_rsp_ready;
  logic            ifu_req_ready;
  logic            lsu_req_ready;
  logic            mem_req_valid;
  logic            mem_rsp_ready;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;

  // Arbitration: a lone requester wins; on a tie the one that was not last wins.
  always_comb begin
    grant_lsu       = bus.lsu_req_valid && (!bus.ifu_req_valid || (last == 1'b0));
    grant_ifu       = bus.ifu_req_valid && !grant_lsu;
    accept          = (state == IDLE) && (grant_lsu || grant_ifu);
    misaligned      = (bus.ifu_addr[1:0] != 2'b00);
    owner_rsp_ready = owner ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;
  end

  // Next-state and per-state outputs; responses are built owner-neutral here
  // and steered to the owner's port below.
  always_comb begin
    state_next    = state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b1;   // stale responses are swallowed outside RSP
    rsp_valid     = 1'b0;
    rsp_data      = 32'h0000_0000;
    rsp_err       = 1'b0;
    case (state)
      IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        if (grant_lsu) begin
          state_next = REQ;
        end else if (grant_ifu) begin
          state_next = misaligned ? ERR : REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          state_next = RSP;
        end else begin
          state_next = REQ;
        end
      end
      RSP: begin
        rsp_valid     = bus.mem_rsp_valid;
        rsp_data      = bus.mem_rsp_rdata;
        rsp_err       = bus.mem_rsp_err;
        mem_rsp_ready = owner_rsp_ready;
        if (bus.mem_rsp_valid && owner_rsp_ready) begin
          state_next = IDLE;
        end else if (!bus.mem_rsp_valid && (TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          state_next = ERR;
        end else begin
          state_next = RSP;
        end
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        if (owner_rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = ERR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ownership and latched request fields, captured on the request handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= 1'b0;
      last  <= 1'b0;
      addr  <= 32'h0000_0000;
      wen   <= 1'b0;
      wdata <= 32'h0000_0000;
      wmask <= 4'h0;
    end else if (accept) begin
      owner <= grant_lsu;
      last  <= grant_lsu;
      addr  <= grant_lsu ? bus.lsu_addr  : bus.ifu_addr;
      wen   <= grant_lsu ? bus.lsu_wen   : 1'b0;
      wdata <= grant_lsu ? bus.lsu_wdata : 32'h0000_0000;
      wmask <= grant_lsu ? bus.lsu_wmask : 4'h0;
    end
  end

  // Response timeout counter: cleared when the memory takes the request,
  // advanced on every RSP cycle without a memory response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == REQ) && bus.mem_req_ready) begin
      cnt <= '0;
    end else if ((state == RSP) && !bus.mem_rsp_valid) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bus.ifu_req_ready = ifu_req_ready;
  assign bus.lsu_req_ready = lsu_req_ready;
  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_addr      = addr;
  assign bus.mem_wen       = wen;
  assign bus.mem_wdata     = wdata;
  assign bus.mem_wmask     = wmask;
  assign bus.mem_rsp_ready = mem_rsp_ready;

  // Only the owner ever sees a response; the other port stays quiet.
  assign bus.ifu_rsp_valid = rsp_valid && !owner;
  assign bus.ifu_rsp_data  = owner ? 32'h0000_0000 : rsp_data;
  assign bus.ifu_rsp_err   = rsp_err && !owner;
  assign bus.lsu_rsp_valid = rsp_valid && owner;
  assign bus.lsu_rsp_rdata = owner ? rsp_data : 32'h0000_0000;
  assign bus.lsu_rsp_err   = rsp_err && owner;

endmodule

// File: tb/tb_ysyx_24070016_mem_arbiter.sv
// Self-checking bench for the memory arbiter: directed scenarios plus a
// randomized transaction stream checked against a transaction-level model.
module tb_ysyx_24070016_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic model_last = 1'b0;   // 0 = IFU, 1 = LSU; who won the previous grant
  logic last_grant;          // observed: 1 if the LSU was granted

  always #5 clk = ~clk;

  ysyx_24070016_mem_arbiter_if bus();

  ysyx_24070016_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h0;
    bus.ifu_rsp_ready = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wmask     = 4'h0;
    bus.lsu_rsp_ready = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    bus.mem_rsp_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    model_last = 1'b0;
  endtask

  // One complete transaction. The expected winner, memory fields and
  // response come from the arbitration rules, not from the design.
  task automatic do_txn(input logic iv, input logic lv, input logic [31:0] ia,
                        input logic [31:0] la, input logic lw, input logic [31:0] lwd,
                        input logic [3:0] lm, input int qd, input int rd, input int ad,
                        input logic [31:0] md, input logic me);
    logic        exp_lsu;
    logic        mis;
    logic [68:0] exp_req;
    logic [33:0] got_rsp;
    logic        other_valid;
    if (iv && lv) exp_lsu = ~model_last;
    else          exp_lsu = lv;
    mis     = !exp_lsu && (ia[1:0] != 2'b00);
    exp_req = exp_lsu ? {la, lw, lwd, lm} : {ia, 1'b0, 32'h0, 4'h0};

    bus.ifu_req_valid = iv;
    bus.ifu_addr      = ia;
    bus.lsu_req_valid = lv;
    bus.lsu_addr      = la;
    bus.lsu_wen       = lw;
    bus.lsu_wdata     = lwd;
    bus.lsu_wmask     = lm;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
      n_fail++;
      $display("FAIL grant: ifu/lsu req_ready got %b want %b",
               {bus.ifu_req_ready, bus.lsu_req_ready}, {~exp_lsu, exp_lsu});
    end
    last_grant = bus.lsu_req_ready;
    tick();
    model_last = exp_lsu;
    // drop the requests and scramble the fields: the arbiter must have latched them
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.ifu_addr      = $urandom;
    bus.lsu_addr      = $urandom;
    bus.lsu_wen       = 1'($urandom);
    bus.lsu_wdata     = $urandom;
    bus.lsu_wmask     = 4'($urandom);
    #1;

    if (mis) begin
      for (int i = 0; i <= ad; i++) begin
        n_cmp++;
        if ({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rsp_data, bus.mem_req_valid, bus.lsu_rsp_valid}
            !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL misalign_err: valid/err/data/mem_req_valid/lsu_valid got %b %b %h %b %b want 1 1 00000000 0 0",
                   bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rsp_data, bus.mem_req_valid, bus.lsu_rsp_valid);
        end
        if (i == ad) bus.ifu_rsp_ready = 1'b1;
        tick();
      end
      bus.ifu_rsp_ready = 1'b0;
    end else begin
      for (int i = 0; i <= qd; i++) begin
        n_cmp++;
        if ({bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
             bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== {1'b1, 1'b0, 1'b0, exp_req}) begin
          n_fail++;
          $display("FAIL mem_req: valid %b addr %h wen %b wdata %h wmask %h, want valid 1 fields %h",
                   bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask, exp_req);
        end
        if (i == qd) bus.mem_req_ready = 1'b1;
        tick();
      end
      bus.mem_req_ready = 1'b0;
      #1;
      for (int i = 0; i < rd; i++) begin
        n_cmp++;
        if ({bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid} !== 3'b000) begin
          n_fail++;
          $display("FAIL rsp_wait: mem_req_valid/ifu_rsp_valid/lsu_rsp_valid got %b want 000",
                   {bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid});
        end
        tick();
        #1;
      end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = md;
      bus.mem_rsp_err   = me;
      for (int i = 0; i <= ad; i++) begin
        if (i == ad) begin
          if (exp_lsu) bus.lsu_rsp_ready = 1'b1;
          else         bus.ifu_rsp_ready = 1'b1;
        end
        #1;
        got_rsp     = exp_lsu ? {bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rsp_rdata}
                              : {bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rsp_data};
        other_valid = exp_lsu ? bus.ifu_rsp_valid : bus.lsu_rsp_valid;
        n_cmp++;
        if ({got_rsp, other_valid, bus.mem_rsp_ready} !== {1'b1, me, md, 1'b0, 1'(i == ad)}) begin
          n_fail++;
          $display("FAIL rsp_route: owner valid/err/data %h other_valid %b mem_rsp_ready %b, want %h 0 %b",
                   got_rsp, other_valid, bus.mem_rsp_ready, {1'b1, me, md}, 1'(i == ad));
        end
        tick();
      end
      bus.mem_rsp_valid = 1'b0;
      bus.ifu_rsp_ready = 1'b0;
      bus.lsu_rsp_ready = 1'b0;
    end
    #1;
    n_cmp++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid, bus.mem_rsp_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL idle_return: ifu_v/lsu_v/mem_req_v/mem_rsp_ready got %b want 0001",
               {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid, bus.mem_rsp_ready});
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_rsp_ready,
         bus.ifu_req_ready, bus.lsu_req_ready} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000100",
               {bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_rsp_ready,
                bus.ifu_req_ready, bus.lsu_req_ready});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== 69'h0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h %b %h %h want all zero",
               bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
    end
    bus.ifu_req_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ifu_only: ready got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    bus.lsu_req_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_tie: ready got %b want 01", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_ifu_read();
    do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 2, 0, 32'h0000_0413, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      do_txn(1'b1, 1'b1, 32'h8000_0000 + 32'(4 * k), 32'h8000_2000 + 32'(4 * k), 1'b0,
             32'h0, 4'h0, 0, 1, 0, $urandom, 1'b0);
      n_cmp++;
      if (last_grant !== 1'((k % 2) == 0)) begin
        n_fail++;
        $display("FAIL rr_order: grant %0d lsu got %b want %b", k, last_grant, 1'((k % 2) == 0));
      end
    end
  endtask

  task automatic test_lsu_write();
    do_txn(1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 3, 1, 1, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_misaligned();
    do_txn(1'b1, 1'b0, 32'h8000_0002, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 2, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    // a response arriving on the last allowed cycle still wins
    do_txn(1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0, 32'h0, 4'h0, 0, 3, 0, 32'hCAFE_F00D, 1'b0);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0080;
    tick();
    model_last        = 1'b0;
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (bus.ifu_rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_early: rsp cycle %0d ifu_rsp_valid got %b want 0", i, bus.ifu_rsp_valid);
      end
      tick();
    end
    #1;
    n_cmp++;
    if ({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rsp_data, bus.lsu_rsp_valid, bus.mem_rsp_ready}
        !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_err: valid/err/data/lsu_v/mem_rsp_ready got %b %b %h %b %b want 1 1 00000000 0 1",
               bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rsp_data, bus.lsu_rsp_valid, bus.mem_rsp_ready);
    end
    bus.ifu_rsp_ready = 1'b1;
    tick();
    bus.ifu_rsp_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hBAD0_BAD0;
    #1;
    n_cmp++;
    if ({bus.mem_rsp_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL stale_rsp: mem_rsp_ready/ifu_v/lsu_v got %b want 100",
               {bus.mem_rsp_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid});
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_mid_rsp();
    do_reset();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_3000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'h5555_AAAA;
    bus.lsu_wmask     = 4'hF;
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_rsp_ready, bus.mem_addr}
        !== {4'b0001, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_rsp: req_v/ifu_v/lsu_v/mem_rsp_ready %b addr %h want 0001 00000000",
               {bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_rsp_ready}, bus.mem_addr);
    end
    do_txn(1'b1, 1'b0, 32'h8000_0100, 32'h0, 1'b0, 32'h0, 4'h0, 1, 0, 0, 32'h0010_0073, 1'b0);
  endtask

  task automatic test_random();
    int          sel;
    logic [31:0] ia;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(1, 3);
      ia  = $urandom;
      if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
      do_txn(1'(sel & 1), 1'((sel >> 1) & 1), ia, $urandom, 1'($urandom), $urandom,
             4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
             $urandom, 1'($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_lsu_write();
    test_misaligned();
    test_timeout();
    test_reset_mid_rsp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24070016_mem_arbiter.md
# ysyx_24070016_mem_arbiter

Arbiter and transaction sequencer sharing the core's single memory port between the instruction fetch unit (read-only) and the load/store unit (read/write). It serves one outstanding transaction at a time. Ties are broken round-robin, and the block latches request fields for the whole transaction. It routes the response back to the owner, and generates error responses for misaligned fetches and memory timeouts. It sits between the IFU/LSU and the memory/bus bridge.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in RSP waiting for `mem_rsp_valid`; 0 disables the timeout.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `ifu_req_valid` / `ifu_req_ready`  in/out  1  fetch request handshake.
- `ifu_addr`  in  32  fetch address.
- `ifu_rsp_valid` / `ifu_rsp_ready`  out/in  1  fetch response handshake.
- `ifu_rsp_data`  out  32  instruction word.
- `ifu_rsp_err`  out  1  fetch error.
- `lsu_req_valid` / `lsu_req_ready`  in/out  1  data request handshake.
- `lsu_addr`  in  32  data address.
- `lsu_wen`  in  1  1 = write.
- `lsu_wdata`  in  32  write data.
- `lsu_wmask`  in  4  byte write mask.
- `lsu_rsp_valid` / `lsu_rsp_ready`  out/in  1  data response handshake.
- `lsu_rsp_rdata`  out  32  read data.
- `lsu_rsp_err`  out  1  data error.
- `mem_req_valid` / `mem_req_ready`  out/in  1  memory request handshake.
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  32/1/32/4  latched request fields.
- `mem_rsp_valid` / `mem_rsp_ready`  in/out  1  memory response handshake.
- `mem_rsp_rdata`, `mem_rsp_err`  in  32/1  memory response.

## Operation
- **State machine:**
  - States: IDLE, REQ, RSP, ERR.
  - Registers: `owner` (0 = IFU, 1 = LSU), `last` (owner of the last grant), latched request fields, and a timeout counter of width clog2(TIMEOUT+1).
- **IDLE arbitration:**
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not `last` is granted.
  - Only the granted requester sees `req_ready` = 1.
  - On the request handshake, latch the fields, set `owner` and `last`, and go to REQ.
  - IFU requests latch `mem_wen` = 0, `mem_wmask` = 0, `mem_wdata` = 0.
- **Misaligned fetch:**
  - An accepted IFU request with `ifu_addr[1:0]` != 0 goes to ERR instead of REQ; no memory access is made.
  - LSU alignment is the LSU's responsibility; LSU addresses are passed unchanged.
- **REQ:**
  - `mem_req_valid` = 1 with the latched fields, held stable until `mem_req_ready`.
  - On the handshake, go to RSP and clear the counter.
  - There is no timeout in REQ; `mem_req_valid` is never withdrawn.
- **RSP:**
  - `mem_rsp_valid`, `rdata` and `err` pass combinationally to the owner's response port.
  - `mem_rsp_ready` = owner's `rsp_ready`.
  - On the handshake, go to IDLE.
  - The counter increments each cycle without `mem_rsp_valid`. When `TIMEOUT` != 0 and the counter reaches `TIMEOUT`, go to ERR.
- **ERR:**
  - The owner sees `rsp_valid` = 1, `err` = 1, data = 0.
  - On the owner's `rsp_ready`, go to IDLE.
- **Stale responses:** `mem_rsp_ready` = 1 in IDLE and ERR, so any late `mem_rsp_valid` after a timeout is consumed and discarded, never forwarded.
- **Non-owner outputs:** the non-owner's `rsp_valid` is always 0. Both `req_ready` are 0 outside IDLE.

## Timing
- **Reset values:**
  - State IDLE, `last` = IFU, counter = 0, latched fields = 0.
  - `mem_req_valid` = 0, both `rsp_valid` = 0.
  - `mem_rsp_ready` = 1 (IDLE). `req_ready` follows the IDLE arbitration.
- **Minimum transaction:**
  - Request handshake at cycle N.
  - `mem_req_valid` high at N+1; if `mem_req_ready` = 1 at N+1, state is RSP at N+2.
  - A response at N+2 with `rsp_ready` = 1 leaves IDLE at N+3, where the next request can be accepted.
  - Back-to-back throughput is one transaction per 3 cycles minimum.
- **Misaligned fetch:** handshake at N, error response visible at N+1.
- **Timeout:** ERR is entered after `TIMEOUT` cycles in RSP without `mem_rsp_valid`. A `mem_rsp_valid` in the same cycle the counter hits `TIMEOUT` wins: it is forwarded normally.
- **Reset mid-transaction:** any state returns to IDLE next cycle and `mem_req_valid` drops. The memory side is reset with the same `rst`.
- **Requester rules:** requesters must hold their request fields stable while `req_valid` && !`req_ready`. The arbiter does not require this after acceptance, because the fields are latched.

## Test plan
- **Single IFU read:** `ifu_addr` = 0x80000000, memory returns 0x00000413 after 2 cycles -> `ifu_rsp_data` = 0x00000413, `err` = 0; `mem_wen`/`mem_wmask` = 0; LSU ports idle.
- **Round-robin on ties:** both requesters continuously valid after reset -> grant order LSU, IFU, LSU, IFU; each response goes only to its owner.
- **LSU write:** addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011 -> `mem_*` fields match exactly and are stable while `mem_req_ready` = 0 for 3 cycles; `lsu_rsp_valid` follows the memory response.
- **Misaligned fetch:** `ifu_addr` = 0x80000002 -> `mem_req_valid` never asserts; `ifu_rsp_err` = 1 one cycle after acceptance.
- **Timeout:** `TIMEOUT` = 4, memory never responds -> error response after 4 RSP cycles. A late `mem_rsp_valid` in IDLE is consumed (`mem_rsp_ready` = 1) and not forwarded.
- **Reset mid-RSP:** `rst` pulsed while in RSP -> next cycle IDLE, all response valids 0, `mem_req_valid` = 0; a subsequent IFU read completes normally.
